// File: rtl/vga_pixel_pipe.sv
// Pixel pipeline between a VGA timing generator and a double-buffered 320x240 RGB332 framebuffer.
// Three-stage path (address, RAM read, colour expand) with frame counting and vsync-aligned buffer flips.
module vga_pixel_pipe #(
    parameter logic [11:0] BLANK_RGB = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic [17:0] fb_addr,
    input  logic [7:0]  fb_data,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] frame_cnt
);

    localparam int unsigned IDX_W   = 17;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RGB_W   = 12;

    logic [9:0]       x_half;
    logic [9:0]       y_half;
    logic [IDX_W-1:0] lin_idx;
    logic             frame_start;
    logic             req_eff;

    logic [IDX_W:0]   fb_addr_q,   fb_addr_d;
    logic [DEPTH-1:0] valid_pipe_q, valid_pipe_d;
    logic [DEPTH-1:0] hs_pipe_q,   hs_pipe_d;
    logic [DEPTH-1:0] vs_pipe_q,   vs_pipe_d;
    logic [RGB_W-1:0] rgb_q,       rgb_d;
    logic             vs_prev_q,   vs_prev_d;
    logic             front_q,     front_d;
    logic             pending_q,   pending_d;
    logic             swap_ack_q,  swap_ack_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // (y/2)*320 + x/2 as (y/2)*256 + (y/2)*64 + x/2
    assign x_half  = x_pos >> 1;
    assign y_half  = y_pos >> 1;
    assign lin_idx = (IDX_W'(y_half) << 8) + (IDX_W'(y_half) << 6) + IDX_W'(x_half);

    // A request seen on the ack cycle is the tail of the one just serviced
    assign frame_start = vs_prev_q & ~vsync_in;
    assign req_eff     = swap_req & ~swap_ack_q;

    always_comb begin
        fb_addr_d    = {front_q, (valid ? lin_idx : IDX_W'(0))};
        valid_pipe_d = {valid_pipe_q[DEPTH-2:0], valid};
        hs_pipe_d    = {hs_pipe_q[DEPTH-2:0], hsync_in};
        vs_pipe_d    = {vs_pipe_q[DEPTH-2:0], vsync_in};
        vs_prev_d    = vsync_in;
        front_d      = front_q;
        pending_d    = pending_q | req_eff;
        swap_ack_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        // fb_data belongs to the pixel now entering the last stage
        if (valid_pipe_q[DEPTH-2]) begin
            rgb_d = {fb_data[7:5], fb_data[7],
                     fb_data[4:2], fb_data[4],
                     fb_data[1:0], fb_data[1:0]};
        end else begin
            rgb_d = BLANK_RGB;
        end

        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (pending_q | req_eff) begin
                front_d    = ~front_q;
                swap_ack_d = 1'b1;
                pending_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr_q    <= '0;
            valid_pipe_q <= '0;
            hs_pipe_q    <= '1;
            vs_pipe_q    <= '1;
            rgb_q        <= BLANK_RGB;
            vs_prev_q    <= 1'b0;
            front_q      <= 1'b0;
            pending_q    <= 1'b0;
            swap_ack_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            fb_addr_q    <= fb_addr_d;
            valid_pipe_q <= valid_pipe_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            rgb_q        <= rgb_d;
            vs_prev_q    <= vs_prev_d;
            front_q      <= front_d;
            pending_q    <= pending_d;
            swap_ack_q   <= swap_ack_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign fb_addr   = fb_addr_q;
    assign r         = rgb_q[11:8];
    assign g         = rgb_q[7:4];
    assign b         = rgb_q[3:0];
    assign de        = valid_pipe_q[DEPTH-1];
    assign hsync     = hs_pipe_q[DEPTH-1];
    assign vsync     = vs_pipe_q[DEPTH-1];
    assign swap_ack  = swap_ack_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe: stimulus pushes expectations from a frame-level model,
// a monitor pops and compares every cycle; a behavioural synchronous RAM supplies fb_data.
module tb_vga_pixel_pipe;

    localparam logic [11:0] BLANK = 12'h5A3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic        valid = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic [17:0] fb_addr;
    logic [7:0]  fb_data = 8'h00;
    logic [3:0]  r, g, b;
    logic        hsync, vsync, de;
    logic [15:0] frame_cnt;

    vga_pixel_pipe #(.BLANK_RGB(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .valid(valid),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .swap_req(swap_req), .swap_ack(swap_ack),
        .fb_addr(fb_addr), .fb_data(fb_data), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_cnt(frame_cnt)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    logic [14:0] pix_q[$];
    logic [17:0] addr_q[$];
    logic [16:0] ctl_q[$];

    logic        m_front, m_pending, m_ack, m_prev_vs;
    logic [15:0] m_cnt;

    function automatic logic [7:0] ram_f(logic [17:0] a);
        if (a[16:0] == 17'd322) return 8'hE0;
        return a[7:0] ^ a[15:8] ^ {5'b0, a[17:16], 1'b1};
    endfunction

    always @(posedge clk) fb_data <= ram_f(fb_addr);

    function automatic logic [11:0] expand(logic [7:0] d);
        int r3, g3, b2;
        r3 = d / 32;
        g3 = (d / 4) % 8;
        b2 = d % 4;
        return {4'(r3 * 2 + r3 / 4), 4'(g3 * 2 + g3 / 4), 4'(b2 * 5)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: one call per pixel clock; outputs scheduled 1 cycle (address, control) or 3 cycles (pixel) later
    task automatic apply(int x, int y, bit v, bit hs, bit vs, bit req);
        int          idx;
        logic [17:0] a;
        logic [7:0]  d;
        logic [11:0] rgb;
        bit          fs, eff;
        x_pos = 10'(x); y_pos = 10'(y); valid = v;
        hsync_in = hs; vsync_in = vs; swap_req = req;
        idx = v ? (y / 2) * 320 + x / 2 : 0;
        a = {m_front, 17'(idx)};
        addr_q.push_back(a);
        d = ram_f(a);
        rgb = v ? expand(d) : BLANK;
        pix_q.push_back({rgb, v, hs, vs});
        fs  = m_prev_vs && !vs;
        eff = req && !m_ack;
        if (fs && (m_pending || eff)) begin
            m_front = !m_front; m_ack = 1'b1; m_pending = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (eff) m_pending = 1'b1;
        end
        if (fs) m_cnt = m_cnt + 16'd1;
        m_prev_vs = vs;
        ctl_q.push_back({m_ack, m_cnt});
    endtask

    task automatic step(int x, int y, bit v, bit hs, bit vs, bit req);
        @(negedge clk);
        apply(x, y, v, hs, vs, req);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_rgb", 32'({r, g, b}), 32'(BLANK));
        chk("rst_de_hs_vs", 32'({de, hsync, vsync}), 32'b011);
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        pix_q.delete(); addr_q.delete(); ctl_q.delete();
        m_front = 0; m_pending = 0; m_ack = 0; m_prev_vs = 0; m_cnt = '0;
        repeat (2) pix_q.push_back({BLANK, 3'b011});
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (addr_q.size() > 0) chk("fb_addr", 32'(fb_addr), 32'(addr_q.pop_front()));
            if (ctl_q.size() > 0)  chk("ack_cnt", 32'({swap_ack, frame_cnt}), 32'(ctl_q.pop_front()));
            if (pix_q.size() > 0)  chk("pixel", 32'({r, g, b, de, hsync, vsync}), 32'(pix_q.pop_front()));
        end
    end

    initial begin
        #5;
        do_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; mon_en = 1'b1;
        apply(0, 0, 0, 1, 1, 0);

        // address/colour corner pixels and an hsync pulse
        step(5, 3, 1, 1, 1, 0);
        step(639, 479, 1, 1, 1, 0);
        step(700, 3, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 1, 0);

        // swap_req held across three frames
        for (int f = 0; f < 3; f++) begin
            repeat (4) step(10, 10, 1, 1, 1, 1);
            repeat (2) step(12, 10, 1, 1, 0, 1);
        end
        repeat (3) step(20, 20, 1, 1, 1, 0);
        // single mid-frame pulse, flip expected only at next frame start
        step(20, 20, 1, 1, 1, 1);
        repeat (3) step(22, 20, 1, 1, 1, 0);
        repeat (2) step(24, 20, 1, 1, 0, 0);
        repeat (3) step(24, 22, 1, 1, 1, 0);
        repeat (2) step(24, 22, 1, 1, 0, 0);
        // request coinciding with the frame start
        repeat (3) step(30, 30, 1, 1, 1, 0);
        step(30, 30, 1, 1, 0, 1);
        step(30, 30, 1, 1, 0, 0);

        // frame counter wrap
        repeat (2) step(40, 40, 1, 1, 1, 0);
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        apply(40, 40, 1, 1, 0, 0);
        repeat (2) step(42, 40, 1, 1, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            int x, y;
            x = $urandom_range(799, 0);
            y = $urandom_range(524, 0);
            step(x, y, (x < 640) && (y < 480) && ($urandom % 8 != 0),
                 $urandom % 6 != 0, $urandom % 10 != 0, $urandom % 5 == 0);
        end

        // reset mid-line with a pending swap and vsync low
        repeat (2) step(50, 50, 1, 1, 0, 0);
        step(52, 50, 1, 1, 0, 1);
        @(negedge clk);
        #3;
        do_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; mon_en = 1'b1;
        apply(60, 60, 1, 1, 0, 0);
        repeat (5) step(62, 60, 1, 1, 0, 0);
        repeat (2) step(64, 60, 1, 1, 1, 0);
        repeat (3) step(66, 60, 1, 1, 0, 0);

        for (int i = 0; i < 500; i++) begin
            int x, y;
            x = $urandom_range(799, 0);
            y = $urandom_range(524, 0);
            step(x, y, (x < 640) && (y < 480),
                 $urandom % 4 != 0, $urandom % 7 != 0, $urandom % 3 == 0);
        end

        repeat (4) @(negedge clk);
        chk("drain", 32'(addr_q.size() + ctl_q.size() + pix_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
